// File: rtl/ccff_pkg.sv
// -----------------------------------------------------------------------------
// ccff_pkg
// Shared definitions for the configuration-chain loader:
//   - ccff_state_e   : pass sequencing states (IDLE / LOAD / CHECK / FINISH)
//   - CCFF_CHAIN_LEN : default number of config flops in the fabric chain
//   - CCFF_BYTE_W    : default width of the host data word
// -----------------------------------------------------------------------------
package ccff_pkg;

    localparam int CCFF_CHAIN_LEN = 16;
    localparam int CCFF_BYTE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } ccff_state_e;

endpackage : ccff_pkg

// File: rtl/ccff_byte_serializer.sv
// -----------------------------------------------------------------------------
// ccff_byte_serializer
// Accepts host bytes and releases them one bit per cycle, LSB first.
//
// Ports:
//   clk_i       : programming clock
//   rst_ni      : synchronous active-low reset
//   active_i    : a pass (LOAD or CHECK) is running
//   room_i      : the chain still needs more bits
//   flush_i     : the bit currently being released is the chain's last one;
//                 whatever is left in the buffer is thrown away
//   in_data_i   : host data word
//   in_valid_i  : host data word valid
//   in_ready_o  : a word is accepted this cycle when in_valid_i is high
//   shift_o     : a bit is being released this cycle
//   bit_o       : the bit being released
// -----------------------------------------------------------------------------
module ccff_byte_serializer
    import ccff_pkg::*;
#(
    parameter int BYTE_W = CCFF_BYTE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              active_i,
    input  logic              room_i,
    input  logic              flush_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              shift_o,
    output logic              bit_o
);

    localparam int BC_W = $clog2(BYTE_W + 1);

    logic [BYTE_W-1:0] buf_q, buf_d;
    logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;

    assign shift_o    = (buf_cnt_q != '0);
    assign bit_o      = buf_q[0];
    // A new word is only taken once the previous one is fully drained; this
    // is what produces the single bubble cycle per byte on the chain side.
    assign in_ready_o = active_i && !shift_o && room_i;

    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        if (in_valid_i && in_ready_o) begin
            buf_d     = in_data_i;
            buf_cnt_d = BC_W'(BYTE_W);
        end else if (shift_o) begin
            buf_d     = buf_q >> 1;
            buf_cnt_d = flush_i ? '0 : (buf_cnt_q - BC_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_q     <= '0;
            buf_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

endmodule : ccff_byte_serializer

// File: rtl/ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader
// Streams host bytes into a CHAIN_LEN-long configuration shift chain (LOAD)
// or streams them again while comparing what falls out of the chain tail
// (CHECK), which also rewrites the chain with the same data.
//
// Ports:
//   prog_clk      : programming clock, also clocks the chain
//   prog_rst_n    : synchronous active-low reset; aborts a pass immediately
//   start         : pulse that begins a pass, honoured only when idle
//   verify        : sampled with start; 0 = LOAD, 1 = CHECK
//   in_data       : host word, shifted LSB first
//   in_valid      : host word valid
//   in_ready      : host word accepted this cycle
//   ccff_head     : serial bit into the chain (registered)
//   ccff_shift_en : chain shifts on this prog_clk edge (registered)
//   ccff_tail     : serial bit out of the chain
//   busy          : pass in progress
//   done          : one-cycle pulse at the end of a pass
//   err           : sticky mismatch flag of the last CHECK pass
//   err_cnt       : mismatches in the last CHECK pass, saturating at CHAIN_LEN
// -----------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
    parameter int BYTE_W    = CCFF_BYTE_W,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              verify,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

    ccff_state_e      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic ser_active;
    logic ser_room;
    logic ser_flush;
    logic ser_shift;
    logic ser_bit;

    assign ser_active = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign ser_room   = (bit_cnt_q < LEN_C);
    // The bit being released now is the chain's final one.
    assign ser_flush  = (bit_cnt_q == (LEN_C - CNT_W'(1)));

    ccff_byte_serializer #(
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clk_i      (prog_clk),
        .rst_ni     (prog_rst_n),
        .active_i   (ser_active),
        .room_i     (ser_room),
        .flush_i    (ser_flush),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .shift_o    (ser_shift),
        .bit_o      (ser_bit)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        head_d     = head_q;
        shift_en_d = ser_shift;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        if (ser_shift) begin
            head_d    = ser_bit;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        // While shift_en is high the chain tail still shows the flop that is
        // about to fall out; with an unchanged stream it equals head_q.
        if ((state_q == ST_CHECK) && shift_en_q && (ccff_tail != head_q)) begin
            err_d = 1'b1;
            if (err_cnt_q != LEN_C) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (start) begin
                    if (verify) begin
                        state_d   = ST_CHECK;
                        err_d     = 1'b0;
                        err_cnt_d = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD, ST_CHECK: begin
                // Leave only after the final shift edge has actually happened.
                if ((bit_cnt_q == LEN_C) && shift_en_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FINISH);
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;

endmodule : ccff_chain_loader

// File: tb/tb_ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_ccff_chain_loader
// Two loaders (16-flop and 12-flop chains) each drive a behavioural shift
// chain. The expected bit stream, final chain image and CHECK mismatch count
// are derived from the byte list and the chain image before the pass.
// -----------------------------------------------------------------------------
module tb_ccff_chain_loader;

    localparam int LEN0 = 16;
    localparam int LEN1 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        start, verify, in_valid;
    logic [1:0][7:0]   in_data;
    logic [1:0]        in_ready, head, shift_en, tail, busy, done, err;
    logic [1:0][4:0]   err_cnt;
    logic [1:0][15:0]  chain_w;

    int errors = 0;
    int checks = 0;

    int shifts [2];
    int dones  [2];
    int hs     [2];
    logic [1:0][15:0] headlog;
    bit q0[$];
    bit q1[$];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L  = (gi == 0) ? LEN0 : LEN1;
            localparam int CW = $clog2(L + 1);
            logic [CW-1:0] cnt_w;
            logic [15:0]   ch_q;

            ccff_chain_loader #(.CHAIN_LEN(L), .BYTE_W(8)) u_dut (
                .prog_clk      (clk),
                .prog_rst_n    (rst_n),
                .start         (start[gi]),
                .verify        (verify[gi]),
                .in_data       (in_data[gi]),
                .in_valid      (in_valid[gi]),
                .in_ready      (in_ready[gi]),
                .ccff_head     (head[gi]),
                .ccff_shift_en (shift_en[gi]),
                .ccff_tail     (tail[gi]),
                .busy          (busy[gi]),
                .done          (done[gi]),
                .err           (err[gi]),
                .err_cnt       (cnt_w)
            );

            // Behavioural chain: position 0 takes the head, tail is position L-1.
            initial ch_q = '0;
            always @(posedge clk) if (shift_en[gi] === 1'b1) ch_q <= {ch_q[14:0], head[gi]};
            assign tail[gi]    = ch_q[L-1];
            assign chain_w[gi] = ch_q;
            assign err_cnt[gi] = 5'(cnt_w);
        end
    endgenerate

    function automatic int len_of(input int i);
        return (i == 0) ? LEN0 : LEN1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every shift cycle the head must be the next stream bit;
    // while idle the block must stay quiet.
    initial begin
        for (int i = 0; i < 2; i++) begin shifts[i] = 0; dones[i] = 0; hs[i] = 0; end
        headlog = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (shift_en[i] === 1'b1) begin
                    bit e;
                    int sz;
                    shifts[i]++;
                    headlog[i] = {headlog[i][14:0], head[i]};
                    sz = (i == 0) ? q0.size() : q1.size();
                    if (sz == 0) begin
                        checks++; errors++;
                        $display("FAIL head_extra%0d: got shift with head %0b, expected no shift", i, head[i]);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("head%0d", i), 32'(head[i]), 32'(e));
                    end
                end
                if (in_valid[i] === 1'b1 && in_ready[i] === 1'b1) hs[i]++;
                if (done[i] === 1'b1) dones[i]++;
                if (busy[i] === 1'b0) begin
                    chk($sformatf("idle_quiet%0d", i), {29'd0, shift_en[i], in_ready[i], done[i]}, 32'd0);
                end
            end
        end
    end

    task automatic push_exp(input int i, input bit b);
        if (i == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic run_pass(input int i, input bit v, input logic [31:0] bytes,
                            input int gap, input bit hold,
                            output int mm, output logic [15:0] exp_chain);
        int L, nb, s0, d0, h0, t, qs;
        logic [15:0] old, mask;
        bit b;
        L = len_of(i);
        nb = (L + 7) / 8;
        old = chain_w[i];
        exp_chain = old;
        mm = 0;
        mask = 16'((32'd1 << L) - 1);
        // Stream bit k is bit k of the byte list (byte 0 lowest, LSB first);
        // it meets chain position L-1-k at the tail and finally rests there.
        for (int k = 0; k < L; k++) begin
            b = bytes[k];
            push_exp(i, b);
            if (old[L-1-k] != b) mm++;
            exp_chain[L-1-k] = b;
        end
        s0 = shifts[i]; d0 = dones[i]; h0 = hs[i];

        start[i] = 1'b1; verify[i] = v;
        @(posedge clk); #1;
        start[i] = 1'b0;
        chk("busy_after_start", 32'(busy[i]), 32'd1);
        for (int n = 0; n < nb; n++) begin
            t = 0;
            while (in_ready[i] !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
            chk("ready_wait_bounded", 32'(t < 100), 32'd1);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk("stall_no_shift", 32'(shift_en[i]), 32'd0);
            end
            in_valid[i] = 1'b1;
            in_data[i]  = bytes[n*8 +: 8];
            @(posedge clk); #1;
            in_valid[i] = (n == nb - 1) ? hold : 1'b0;
            in_data[i]  = 8'hEE;
        end
        t = 0;
        while (dones[i] == d0 && t < 300) begin @(negedge clk); t++; end
        chk("done_wait_bounded", 32'(t < 300), 32'd1);
        in_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        qs = (i == 0) ? q0.size() : q1.size();
        chk("done_pulses", 32'(dones[i] - d0), 32'd1);
        chk("shift_count", 32'(shifts[i] - s0), 32'(L));
        chk("bytes_taken", 32'(hs[i] - h0), 32'(nb));
        chk("stream_drained", 32'(qs), 32'd0);
        chk("chain_image", 32'(chain_w[i] & mask), 32'(exp_chain & mask));
        chk("busy_after_done", 32'(busy[i]), 32'd0);
        if (v) begin
            chk("err_flag", 32'(err[i]), 32'(mm != 0));
            chk("err_cnt", 32'(err_cnt[i]), 32'(mm));
        end
        $display("pass inst=%0d %s bytes=0x%0h gap=%0d mm=%0d chain=0x%0h",
                 i, v ? "CHECK" : "LOAD", bytes, gap, mm, chain_w[i] & mask);
    endtask

    initial begin
        int mm;
        int s0, d0, t;
        logic [15:0] ec, old;
        logic [1:0][31:0] last_bytes;
        logic [31:0] rb;

        rst_n = 1'b0; start = 2'b11; verify = 2'b00; in_valid = 2'b11; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_outputs", {25'd0, in_ready[i], head[i], shift_en[i], busy[i], done[i], err[i]}, 32'd0);
            chk("rst_err_cnt", 32'(err_cnt[i]), 32'd0);
        end
        start = 2'b00; in_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16-flop chain: load, verify, corrupted verify, load under backpressure.
        run_pass(0, 1'b0, 32'h0000_3CA5, 0, 1'b0, mm, ec);
        chk("lit_chain_a53c", 32'(chain_w[0]), 32'h0000_A53C);
        chk("lit_heads_a53c", 32'(headlog[0]), 32'h0000_A53C);
        run_pass(0, 1'b1, 32'h0000_3CA5, 0, 1'b0, mm, ec);
        chk("lit_check_same_mm", 32'(err_cnt[0]), 32'd0);
        run_pass(0, 1'b1, 32'h0000_3CA4, 0, 1'b0, mm, ec);
        chk("lit_check_a4_err", 32'(err[0]), 32'd1);
        chk("lit_check_a4_mm", 32'(err_cnt[0]), 32'd1);
        chk("lit_chain_253c", 32'(chain_w[0]), 32'h0000_253C);
        run_pass(0, 1'b0, 32'h0000_3CA5, 5, 1'b0, mm, ec);
        chk("lit_chain_bp", 32'(chain_w[0]), 32'h0000_A53C);

        // 12-flop chain: partial last byte with in_valid held high afterwards.
        run_pass(1, 1'b0, 32'h0000_0FFF, 0, 1'b1, mm, ec);
        chk("lit_chain_fff", 32'(chain_w[1][11:0]), 32'h0000_0FFF);
        run_pass(1, 1'b1, 32'h0000_00FF, 2, 1'b1, mm, ec);
        chk("lit_check_ff00_mm", 32'(err_cnt[1]), 32'd4);
        chk("lit_chain_ff0", 32'(chain_w[1][11:0]), 32'h0000_0FF0);

        // Reset during a LOAD after 7 shifts.
        old = chain_w[0];
        s0 = shifts[0]; d0 = dones[0];
        for (int k = 0; k < 8; k++) push_exp(0, 1'((8'h5A >> k) & 8'h01));
        start[0] = 1'b1; verify[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 8'h5A;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        t = 0;
        while (shifts[0] - s0 < 6 && t < 100) begin @(posedge clk); #1; t++; end
        chk("abort_wait_bounded", 32'(t < 100), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete();
        repeat (5) @(posedge clk);
        #1;
        ec = old;
        for (int k = 0; k < 7; k++) ec = {ec[14:0], 1'((8'h5A >> k) & 8'h01)};
        chk("abort_shifts", 32'(shifts[0] - s0), 32'd7);
        chk("abort_no_done", 32'(dones[0] - d0), 32'd0);
        chk("abort_idle", 32'(busy[0]), 32'd0);
        chk("abort_chain", 32'(chain_w[0]), 32'(ec));
        run_pass(0, 1'b0, 32'h0000_9D61, 0, 1'b0, mm, ec);
        run_pass(0, 1'b1, 32'h0000_9D61, 1, 1'b0, mm, ec);
        chk("lit_after_abort_mm", 32'(err_cnt[0]), 32'd0);
        last_bytes[0] = 32'h0000_9D61;
        last_bytes[1] = 32'h0000_00FF;

        // Randomised passes on both chains.
        for (int n = 0; n < 24; n++) begin
            int i;
            bit v;
            i = int'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            rb = $urandom;
            if (v && $urandom_range(0, 1) == 1) rb = last_bytes[i];
            run_pass(i, v, rb, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), mm, ec);
            last_bytes[i] = rb;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ccff_chain_loader

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain bitstream into the head of a `p_ccff` shift chain (`ccff_head`) and qualifies each chain shift with `ccff_shift_en`.
- Optionally reads the chain back from `ccff_tail` on a second pass and compares it against the same stream.
- Sits between the host byte stream (SPI/UART front end) and the top-level fabric configuration chain.
- Is the transmit/readback end of the chain protocol.

Parameters:
- `CHAIN_LEN`, 16: total number of config flops in the chain (bits per load pass); minimum 1.
- `BYTE_W`, 8: width of the host data word.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the bit counter; derived, do not override.

Ports:
- `prog_clk` input 1: programming clock; also clocks the chain.
- `prog_rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle pulse that begins a pass; ignored unless in IDLE.
- `verify` input 1: sampled with `start`; 0 = LOAD pass, 1 = CHECK pass.
- `in_data` input `BYTE_W`: host data word, shifted LSB first.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `ccff_head` output 1: serial bit into the chain.
- `ccff_shift_en` output 1: chain shifts on this `prog_clk` edge (gating enable for the chain clock).
- `ccff_tail` input 1: serial bit out of the chain.
- `busy` output 1: pass in progress.
- `done` output 1: one-cycle pulse at end of pass.
- `err` output 1: sticky mismatch flag for the CHECK pass.
- `err_cnt` output `CNT_W`: number of mismatches in the last CHECK pass; saturates at `CHAIN_LEN`.

Behaviour:
- Reset (`prog_rst_n`=0 at a `prog_clk` edge): state IDLE; all outputs 0 (`in_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `err`, `err_cnt`); byte buffer and counters cleared.
- Reset mid-pass aborts immediately. The chain holds partial contents and no `done` pulse is produced.
- States: IDLE, LOAD, CHECK, FINISH.
  - IDLE + `start` → LOAD (`verify`=0) or CHECK (`verify`=1).
  - On entry to CHECK, `err` and `err_cnt` are cleared.
  - `start` during a pass is ignored.
- Bit counter `bit_cnt` starts at 0. Byte buffer holds up to `BYTE_W` bits; `buf_cnt` counts the remaining bits.
- `in_ready` = state is LOAD or CHECK && `buf_cnt`==0 && `bit_cnt`<`CHAIN_LEN`.
  - Handshake: transfer on `in_valid && in_ready`.
  - Next cycle: buffer = `in_data`, `buf_cnt` = `BYTE_W`.
  - Exactly one idle cycle per accepted byte; `in_valid` low stalls the pass indefinitely.
- Each cycle with `buf_cnt`>0 (registered outputs):
  - `ccff_head` = buffer[0] and `ccff_shift_en` = 1.
  - Buffer shifts right; `buf_cnt`−1; `bit_cnt`+1.
  - Otherwise `ccff_shift_en` = 0 and `ccff_head` holds its last value.
- Bit ordering: the first bit shifted ends in chain position `CHAIN_LEN`−1 (the tail flop); the last bit shifted ends in position 0.
- Partial last byte: when `bit_cnt` reaches `CHAIN_LEN`, the remaining buffer bits are discarded, `buf_cnt` is forced to 0, and no further bytes are accepted.
- CHECK pass:
  - Shifts identically to LOAD.
  - On each shift cycle the block compares `ccff_tail` (sampled the cycle `ccff_shift_en`=1) with the bit being driven onto `ccff_head`.
  - The chain holds the previous pass's contents, so a correct readback of an identical stream gives zero mismatches.
  - On a mismatch: `err` ← 1 and `err_cnt` +1, saturating.
  - CHECK also rewrites the chain with the same data.
- When `bit_cnt`==`CHAIN_LEN` and the last shift has completed:
  - → FINISH for 1 cycle, with `done`=1.
  - → IDLE.
- `busy` = state ≠ IDLE.
- Simultaneous `start` + `in_valid` in IDLE: the byte is not accepted (`in_ready`=0 in IDLE).
- `CHAIN_LEN`=1: exactly one shift, one byte consumed.

Decomposition:
- Shared package `ccff_pkg`: state enum (IDLE/LOAD/CHECK/FINISH) and the default `CHAIN_LEN`.
- One natural sub-module, `ccff_byte_serializer`: byte buffer, `buf_cnt`, `in_ready` generation and LSB-first shift-out. The FSM, `bit_cnt` and compare logic stay in the top module.

Test Plan:
- Reset: hold `prog_rst_n`=0 with `in_valid`=1 → all outputs 0; `in_ready`=0.
- LOAD, `CHAIN_LEN`=16, bytes 0xA5, 0x3C with `verify`=0 → exactly 16 `ccff_shift_en` cycles; `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `done` pulse once; behavioural chain `mem_out[15..0]` matches.
- Partial byte, `CHAIN_LEN`=12, bytes 0xFF, 0x0F → 12 shifts; upper 4 bits of 0x0F never driven; `in_ready` stays 0 after the second byte.
- CHECK after LOAD of the same stream → `err`=0, `err_cnt`=0. CHECK with 0xA4 in place of 0xA5 → `err`=1, `err_cnt`=1.
- Backpressure: drop `in_valid` for 5 cycles mid-pass → `ccff_shift_en` held 0, no bit lost, final chain contents correct.
- Reset asserted after 7 shifts, then a new LOAD → no `done` pulse from the aborted pass; the new pass completes in 16 shifts with correct contents.
